// File: rtl/debug_frame_rx.sv
// debug_frame_rx: reassembles MSB-first byte frames closed by a terminator into a word,
// flagging bad terminators and stalled frames with a saturating error count.
module debug_frame_rx #(
  parameter int                DATA_WIDTH    = 8,
  parameter logic [7:0]        TERMINATOR    = 8'h0A,
  parameter logic [27:0]       TIMEOUT_TICKS = 28'd2200000,
  parameter int                ERR_CNT_WIDTH = 8
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [DATA_WIDTH-1:0]    word_out,
  output logic                     word_valid,
  output logic                     frame_error,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic                     busy,
  output logic [1:0]               state
);
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int BCW = $clog2(NBYTES + 1);
  localparam int ICW = $clog2(TIMEOUT_TICKS) + 1;
  localparam logic [BCW-1:0] LAST_IDX = BCW'(NBYTES - 1);
  localparam logic [ICW-1:0] TMAX = ICW'(TIMEOUT_TICKS - 28'd1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_COLLECT = 2'd1, S_WAIT_TERM = 2'd2, S_DISCARD = 2'd3} state_t;

  state_t                   r_state;
  logic [DATA_WIDTH-1:0]    r_shreg;
  logic [DATA_WIDTH-1:0]    r_word;
  logic [BCW-1:0]           r_bcnt;
  logic [ICW-1:0]           r_idle;
  logic [ERR_CNT_WIDTH-1:0] r_err_count;
  logic                     r_word_valid;
  logic                     r_frame_error;

  logic [DATA_WIDTH-1:0]    w_shift;
  logic [ERR_CNT_WIDTH-1:0] w_err_next;
  logic                     w_timeout;
  logic                     w_is_term;

  // Cast keeps the low DATA_WIDTH bits, which also covers the single-byte case.
  assign w_shift    = DATA_WIDTH'({r_shreg, rx_data});
  assign w_err_next = &r_err_count ? r_err_count : r_err_count + 1'b1;
  assign w_timeout  = (r_state != S_IDLE) && (r_idle == TMAX);
  assign w_is_term  = (rx_data == TERMINATOR);

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_shreg       <= '0;
      r_word        <= '0;
      r_bcnt        <= '0;
      r_idle        <= '0;
      r_err_count   <= '0;
      r_word_valid  <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_word_valid  <= 1'b0;
      r_frame_error <= 1'b0;
      r_idle        <= (rx_valid || r_state == S_IDLE) ? '0 : r_idle + 1'b1;
      if (rx_valid) begin
        case (r_state)
          S_IDLE: begin
            r_shreg <= w_shift;
            r_bcnt  <= BCW'(1);
            r_state <= (NBYTES == 1) ? S_WAIT_TERM : S_COLLECT;
          end
          S_COLLECT: begin
            r_shreg <= w_shift;
            r_bcnt  <= r_bcnt + 1'b1;
            if (r_bcnt == LAST_IDX) r_state <= S_WAIT_TERM;
          end
          S_WAIT_TERM: begin
            if (w_is_term) begin
              r_word       <= r_shreg;
              r_word_valid <= 1'b1;
              r_state      <= S_IDLE;
            end else begin
              r_frame_error <= 1'b1;
              r_err_count   <= w_err_next;
              r_state       <= S_DISCARD;
            end
          end
          S_DISCARD: if (w_is_term) r_state <= S_IDLE;
        endcase
      end else if (w_timeout) begin
        // A stalled discard just resynchronises; a stalled frame is an error.
        r_state <= S_IDLE;
        if (r_state != S_DISCARD) begin
          r_frame_error <= 1'b1;
          r_err_count   <= w_err_next;
        end
      end
    end
  end

  assign word_out    = r_word;
  assign word_valid  = r_word_valid;
  assign frame_error = r_frame_error;
  assign err_count   = r_err_count;
  assign busy        = (r_state != S_IDLE);
  assign state       = r_state;
endmodule

// File: tb/tb_debug_frame_rx.sv
// tb_debug_frame_rx: frame-level reference model checked every cycle, plus directed
// literal expectations for the good-frame, resync, timeout, reset and saturation cases.
module tb_debug_frame_rx;
  localparam int NB = 2;
  localparam int T = 50;

  logic        clk_in = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [15:0] word_out;
  logic        word_valid;
  logic        frame_error;
  logic [1:0]  err_count;
  logic        busy;
  logic [1:0]  state;

  int errors = 0;
  int checks = 0;
  int n_wv = 0;
  int n_fe = 0;

  debug_frame_rx #(
    .DATA_WIDTH(16), .TERMINATOR(8'h0A), .TIMEOUT_TICKS(28'd50), .ERR_CNT_WIDTH(2)
  ) dut (
    .clk_in(clk_in), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .word_out(word_out), .word_valid(word_valid), .frame_error(frame_error),
    .err_count(err_count), .busy(busy), .state(state)
  );

  always #5 clk_in = ~clk_in;

  // Model: the bytes of the frame so far, whether we are skipping to a terminator,
  // and how many edges have passed since the last byte.
  logic [7:0]  m_frame[$];
  bit          m_disc = 1'b0;
  int          m_gap = 0;
  logic [15:0] m_word = '0;
  logic        m_wv = 1'b0;
  logic        m_fe = 1'b0;
  int          m_err = 0;
  logic [1:0]  m_state;

  always @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      m_frame.delete();
      m_disc = 1'b0;
      m_gap = 0;
      m_word = '0;
      m_wv = 1'b0;
      m_fe = 1'b0;
      m_err = 0;
    end else begin
      m_wv = 1'b0;
      m_fe = 1'b0;
      if (rx_valid) begin
        m_gap = 0;
        if (m_disc) m_disc = (rx_data != 8'h0A);
        else if (m_frame.size() < NB) m_frame.push_back(rx_data);
        else begin
          if (rx_data == 8'h0A) begin
            m_word = '0;
            foreach (m_frame[i]) m_word = (m_word << 8) | 16'(m_frame[i]);
            m_wv = 1'b1;
          end else begin
            m_fe = 1'b1;
            m_disc = 1'b1;
          end
          m_frame.delete();
        end
      end else if (m_frame.size() > 0 || m_disc) begin
        m_gap++;
        if (m_gap == T) begin
          if (!m_disc) m_fe = 1'b1;
          m_frame.delete();
          m_disc = 1'b0;
        end
      end
      if (m_fe && m_err < 3) m_err++;
    end
  end

  assign m_state = m_disc ? 2'd3 : (m_frame.size() == 0) ? 2'd0 : (m_frame.size() < NB) ? 2'd1 : 2'd2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_in) begin
    if (reset) begin
      chk("model_word_out", 32'(word_out), 32'(m_word));
      chk("model_word_valid", 32'(word_valid), 32'(m_wv));
      chk("model_frame_error", 32'(frame_error), 32'(m_fe));
      chk("model_err_count", 32'(err_count), 32'(m_err));
      chk("model_state", 32'(state), 32'(m_state));
      chk("model_busy", 32'(busy), 32'(m_state != 2'd0));
      n_wv += int'(word_valid);
      n_fe += int'(frame_error);
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk_in);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk_in);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  int wv0, fe0;

  initial begin
    repeat (3) @(negedge clk_in);
    chk("reset_word_out", 32'(word_out), 0);
    chk("reset_state", 32'(state), 0);
    chk("reset_busy", 32'(busy), 0);
    reset = 1'b1;
    idle(2);

    // Good frame, bytes spaced apart
    wv0 = n_wv;
    send(8'hA5); idle(9);
    send(8'h3C); idle(9);
    chk("t1_pre_state", 32'(state), 2);
    send(8'h0A);
    chk("t1_wv_pulse", 32'(word_valid), 1);
    chk("t1_word", 32'(word_out), 32'hA53C);
    idle(1);
    chk("t1_wv_one_cycle", 32'(word_valid), 0);
    chk("t1_err", 32'(err_count), 0);
    chk("t1_wv_count", 32'(n_wv - wv0), 1);

    // Terminator-valued data bytes
    wv0 = n_wv; fe0 = n_fe;
    send(8'h0A); send(8'h0A); send(8'h0A); idle(2);
    chk("t2_word", 32'(word_out), 32'h0A0A);
    chk("t2_wv_count", 32'(n_wv - wv0), 1);
    chk("t2_fe_count", 32'(n_fe - fe0), 0);

    // Bad terminator then resync
    send(8'h12); send(8'h34); send(8'h56);
    chk("t3_fe_pulse", 32'(frame_error), 1);
    chk("t3_err", 32'(err_count), 1);
    chk("t3_state_discard", 32'(state), 3);
    wv0 = n_wv;
    send(8'h77); send(8'h0A); idle(1);
    chk("t3_resync_idle", 32'(state), 0);
    chk("t3_no_wv", 32'(n_wv - wv0), 0);
    send(8'h12); send(8'h34); send(8'h0A);
    chk("t3_word", 32'(word_out), 32'h1234);
    idle(2);

    // Timeout after a lone byte
    send(8'h12);
    idle(49);
    chk("t4_no_fe_early", 32'(frame_error), 0);
    chk("t4_busy", 32'(busy), 1);
    idle(1);
    chk("t4_fe_timeout", 32'(frame_error), 1);
    chk("t4_err", 32'(err_count), 2);
    chk("t4_state_idle", 32'(state), 0);
    send(8'hAB); send(8'hCD); send(8'h0A);
    chk("t4_word", 32'(word_out), 32'hABCD);
    idle(2);

    // Byte landing on the expiry cycle suppresses the timeout
    send(8'h43);
    idle(48);
    send(8'h21);
    chk("t4b_no_fe", 32'(frame_error), 0);
    chk("t4b_state_wait", 32'(state), 2);
    send(8'h0A);
    chk("t4b_word", 32'(word_out), 32'h4321);
    chk("t4b_err", 32'(err_count), 2);
    idle(2);

    // Asynchronous reset mid-frame
    send(8'h12);
    #2 reset = 1'b0;
    #1;
    chk("t5_rst_word", 32'(word_out), 0);
    chk("t5_rst_err", 32'(err_count), 0);
    chk("t5_rst_state", 32'(state), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    idle(3);
    reset = 1'b1;
    wv0 = n_wv; fe0 = n_fe;
    idle(2);
    chk("t5_no_pulse", 32'(n_wv - wv0 + n_fe - fe0), 0);
    send(8'h56); send(8'h78); send(8'h0A);
    chk("t5_word", 32'(word_out), 32'h5678);
    idle(2);

    // Error counter saturation
    fe0 = n_fe;
    for (int i = 0; i < 5; i++) begin
      send(8'h12); send(8'h34); send(8'h56); send(8'h0A); idle(1);
    end
    chk("t6_fe_count", 32'(n_fe - fe0), 5);
    chk("t6_err_sat", 32'(err_count), 3);
    chk("t6_state", 32'(state), 0);

    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/debug_frame_rx.md
Name: debug_frame_rx

Overview:
- Receive-side counterpart of the periodic debug word transmitter.
- Consumes the byte stream from a uart_rx instance. Each frame is DATA_WIDTH/8 raw data bytes, MSB byte first, followed by one terminator byte (newline).
- Reassembles the bytes into a DATA_WIDTH word and presents it with a one-cycle valid pulse.
- Detects malformed or stalled frames, counts them, and resynchronises on terminator or idle gap. Used on loopback benches and by a host-side FPGA monitor.

Parameters:
- DATA_WIDTH, 8: reassembled word width; multiple of 8, minimum 8. NBYTES = DATA_WIDTH/8.
- TERMINATOR, 8'h0A: frame terminator byte value.
- TIMEOUT_TICKS, 28'd2200000: inter-byte idle limit in clk_in cycles (about 100 ms at 22 MHz); minimum 2.
- ERR_CNT_WIDTH, 8: width of the saturating error counter.

Ports:
- clk_in  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset. Asserted (0) clears all state immediately; deassertion is synchronous to clk_in upstream.
- rx_data  input  8  received byte; valid only when rx_valid=1.
- rx_valid  input  1  one-cycle strobe per received byte (uart_rx o_recvdata).
- word_out  output  DATA_WIDTH  last successfully received word; held until the next good frame.
- word_valid  output  1  one-cycle pulse when word_out updates.
- frame_error  output  1  one-cycle pulse per detected bad frame.
- err_count  output  ERR_CNT_WIDTH  saturating count of frame_error pulses.
- busy  output  1  high whenever state != IDLE.
- state  output  2  current FSM state encoding, for debug.

Behaviour:
- Reset values (reset=0, asynchronous):
  - word_out=0, word_valid=0, frame_error=0, err_count=0, busy=0, state=IDLE.
  - shift register=0, byte counter=0, idle counter=0.
- FSM states: IDLE=2'd0, COLLECT=2'd1, WAIT_TERM=2'd2, DISCARD=2'd3.
- Framing is positional. Every byte in IDLE or COLLECT is data, including bytes equal to TERMINATOR. TERMINATOR is compared only in WAIT_TERM and DISCARD.
- IDLE, rx_valid=1:
  - shreg <= {shreg[DATA_WIDTH-9:0], rx_data}; byte counter <= 1.
  - Next state WAIT_TERM if NBYTES==1, else COLLECT.
- COLLECT, rx_valid=1:
  - Shift rx_data in; byte counter increments.
  - When the counter reaches NBYTES (i.e. this byte is byte NBYTES), next state WAIT_TERM.
- WAIT_TERM, rx_valid=1:
  - rx_data==TERMINATOR: word_out <= shreg; word_valid=1 for exactly the next cycle; next state IDLE.
  - Otherwise: frame_error pulse; err_count+1; next state DISCARD. word_out is unchanged.
- DISCARD, rx_valid=1:
  - rx_data==TERMINATOR: next state IDLE, no pulse.
  - Otherwise: stay in DISCARD.
- Latency: word_valid rises on the clk_in edge after the edge that samples the terminator's rx_valid. Likewise frame_error rises one edge after the offending byte.
- Idle timeout:
  - The idle counter clears on any rx_valid and in IDLE; otherwise it increments each cycle while busy.
  - At count==TIMEOUT_TICKS-1 in COLLECT or WAIT_TERM: frame_error pulse, err_count+1, partial word dropped, next state IDLE, counter cleared.
  - At count==TIMEOUT_TICKS-1 in DISCARD: next state IDLE, no error.
- Simultaneous events:
  - rx_valid in the same cycle as timeout expiry: the byte is processed and the timeout is suppressed (counter clears).
  - frame_error and word_valid are never asserted in the same cycle.
- err_count saturates at all-ones. Further errors still pulse frame_error but do not wrap the counter.
- Back-to-back frames with no gap (terminator immediately followed by the next data byte) are accepted. The IDLE entry cycle does not drop a byte, because bytes arrive at most one per UART frame.
- Reset asserted mid-frame discards the partial word and clears word_out; no pulses are generated on reset release.
- Width rules: byte counter is $clog2(NBYTES+1) bits; idle counter is $clog2(TIMEOUT_TICKS)+1 bits. All comparisons are at full width with no truncation.

Test Plan:
- Good frame: DATA_WIDTH=16; bytes A5,3C,0A, spaced 10 cycles apart -> word_valid high exactly 1 cycle, one edge after 0A; word_out=16'hA53C; err_count=0.
- Terminator-valued data: bytes 0A,0A,0A -> word_out=16'h0A0A, one word_valid pulse, no frame_error.
- Bad terminator and resync: bytes 12,34,56 -> frame_error pulse, err_count=1, state=DISCARD. Then 77,0A -> IDLE with no word_valid. Then 12,34,0A -> word_out=16'h1234.
- Timeout: TIMEOUT_TICKS=50; byte 12 then silence -> frame_error 50 cycles later, err_count=1, state IDLE. Then AB,CD,0A -> word_out=16'hABCD. A byte arriving exactly on cycle 49 suppresses the timeout.
- Saturation: ERR_CNT_WIDTH=2; five bad-terminator frames -> five frame_error pulses, err_count stays 2'b11.
- Reset mid-frame: after byte 12, drive reset=0 for 3 cycles (async, between edges) -> all outputs 0 immediately. After release, bytes 56,78,0A -> word_out=16'h5678 with no stale 12 byte.
